// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the two requester ports (line-buffer writer, filter-engine reader)
//   and the single-port SRAM pins that the arbiter shares between them.
//
//   Modports
//     slave  : the arbiter. Takes requests and SRAM read data, returns grants,
//              the read-data strobe and the SRAM control/address/data pins.
//     master : the environment (requesters plus SRAM). Drives requests and
//              SRAM read data, observes grants and SRAM pins.
//
//   Signals
//     wr_req / wr_addr / wr_data : writer request, address, data
//     wr_gnt                     : write accepted at the end of this cycle
//     rd_req / rd_addr           : reader request, address
//     rd_gnt                     : read accepted at the end of this cycle
//     rd_valid / rd_data         : read data, one cycle after rd_gnt
//     mem_cs / mem_we / mem_addr / mem_din / mem_dout : SRAM pins
interface sram_port_arbiter_if #(
  parameter int WD    = 128,
  parameter int DEPTH = 64,
  parameter int WA    = $clog2(DEPTH)
);

  logic          wr_req;
  logic [WA-1:0] wr_addr;
  logic [WD-1:0] wr_data;
  logic          wr_gnt;

  logic          rd_req;
  logic [WA-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [WD-1:0] rd_data;

  logic          mem_cs;
  logic          mem_we;
  logic [WA-1:0] mem_addr;
  logic [WD-1:0] mem_din;
  logic [WD-1:0] mem_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  mem_dout,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
    output mem_cs, mem_we, mem_addr, mem_din
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd_req, rd_addr,
    output mem_dout,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
    input  mem_cs, mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM between the Filter2D line-buffer writer and
//   the filter-engine reader. At most one access is granted per cycle, with
//   round-robin priority and a bounded burst hold of MAX_BURST consecutive
//   grants while the other side waits. Read data comes back with rd_valid one
//   cycle after rd_gnt, matching the SRAM's one-cycle read latency.
//
//   Ports
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : sram_port_arbiter_if.slave (requester handshakes + SRAM pins)
//
//   Arbitration state
//     state    | meaning
//     ---------+-----------------------------------------------------------
//     OWN_IDLE | no grant last cycle; ties go to the side that is not last_q
//     OWN_WR   | writer was granted last cycle; cnt_q counts its run length
//     OWN_RD   | reader was granted last cycle; cnt_q counts its run length
module sram_port_arbiter #(
  parameter int WD        = 128,
  parameter int DEPTH     = 64,
  parameter int WA        = $clog2(DEPTH),
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  bus
);

  localparam int            CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_WR   = 2'd1,
    OWN_RD   = 2'd2
  } owner_t;

  owner_t        owner_q, owner_d;
  owner_t        last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          rd_valid_q;

  logic          gnt_wr;
  logic          gnt_rd;

  // State register: async reset clears ownership immediately, and last_q
  // resets to the reader so the writer wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_IDLE;
      last_q     <= OWN_RD;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= gnt_rd;
    end
  end

  // Grant decision and next state.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_wr  = 1'b0;
    gnt_rd  = 1'b0;

    unique case (owner_q)
      OWN_IDLE: begin
        if (bus.wr_req && (!bus.rd_req || last_q == OWN_RD)) begin
          gnt_wr = 1'b1;
        end else if (bus.rd_req) begin
          gnt_rd = 1'b1;
        end
      end
      OWN_WR: begin
        // Keep the run while under the burst limit, yield if the reader
        // waits, otherwise keep serving the lone writer with a fresh run.
        if (bus.wr_req && cnt_q < MAX_CNT) begin
          gnt_wr = 1'b1;
        end else if (bus.rd_req) begin
          gnt_rd = 1'b1;
        end else if (bus.wr_req) begin
          gnt_wr = 1'b1;
        end
      end
      OWN_RD: begin
        if (bus.rd_req && cnt_q < MAX_CNT) begin
          gnt_rd = 1'b1;
        end else if (bus.wr_req) begin
          gnt_wr = 1'b1;
        end else if (bus.rd_req) begin
          gnt_rd = 1'b1;
        end
      end
      default: begin
        owner_d = OWN_IDLE;
      end
    endcase

    if (gnt_wr) begin
      owner_d = OWN_WR;
      last_d  = OWN_WR;
      cnt_d   = (owner_q == OWN_WR && cnt_q < MAX_CNT) ? cnt_q + ONE_CNT : ONE_CNT;
    end else if (gnt_rd) begin
      owner_d = OWN_RD;
      last_d  = OWN_RD;
      cnt_d   = (owner_q == OWN_RD && cnt_q < MAX_CNT) ? cnt_q + ONE_CNT : ONE_CNT;
    end else begin
      owner_d = OWN_IDLE;
      cnt_d   = '0;
    end
  end

  // Grants are masked during reset: state is already IDLE, but an IDLE
  // arbiter would otherwise still grant a pending request.
  assign bus.wr_gnt   = gnt_wr & ~rst;
  assign bus.rd_gnt   = gnt_rd & ~rst;

  assign bus.mem_cs   = bus.wr_gnt | bus.rd_gnt;
  assign bus.mem_we   = bus.wr_gnt;
  assign bus.mem_addr = bus.wr_gnt ? bus.wr_addr : bus.rd_addr;
  assign bus.mem_din  = bus.wr_data;

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = bus.mem_dout;

endmodule
